// File: rtl/sprite_coord_seq.sv
// Sprite coordinate sequencer: picks one packed (x,y) channel per beat, either by manual load or by scanning an enable mask.
// Optional build macro SPRITE_COORD_SEQ_CLAMP_EN saturates captured coordinates to X_MAX/Y_MAX.
module sprite_coord_seq #(
    parameter int NUM_CH = 4,
    parameter int X_W    = 11,
    parameter int Y_W    = 10,
    parameter int X_MAX  = 639,
    parameter int Y_MAX  = 479,
    parameter int SEL_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NUM_CH*X_W-1:0] x_bus,
    input  logic [NUM_CH*Y_W-1:0] y_bus,
    input  logic                  mode,
    input  logic [SEL_W-1:0]      selector,
    input  logic                  load,
    input  logic                  start,
    input  logic [NUM_CH-1:0]     ch_en,
    output logic [X_W-1:0]        out_x,
    output logic [Y_W-1:0]        out_y,
    output logic [SEL_W-1:0]      out_ch,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  done,
    output logic                  sel_err
);

    localparam int PTR_W = SEL_W + 1;
`ifdef SPRITE_COORD_SEQ_CLAMP_EN
    localparam bit CLAMP_ON = 1'b1;
`else
    localparam bit CLAMP_ON = 1'b0;
`endif
    localparam logic [X_W-1:0] X_LIM = X_W'(X_MAX);
    localparam logic [Y_W-1:0] Y_LIM = Y_W'(Y_MAX);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [NUM_CH-1:0]  r_mask;
    logic [PTR_W-1:0]   r_ptr;
    logic [X_W-1:0]     r_outX;
    logic [Y_W-1:0]     r_outY;
    logic [SEL_W-1:0]   r_outCh;
    logic               r_outValid;
    logic               r_busy;
    logic               r_done;
    logic               r_selErr;

    logic               w_found;
    logic [SEL_W-1:0]   w_scanIdx;
    logic [NUM_CH-1:0]  w_scanHot;
    logic [NUM_CH-1:0]  w_maskRest;
    logic               w_free;
    logic               w_transfer;
    logic               w_selValid;
    logic               w_manualReq;
    logic               w_manualGo;
    logic               w_manualErr;
    logic               w_scanGo;
    logic               w_capture;
    logic [SEL_W-1:0]   w_capIdx;
    logic [X_W-1:0]     w_rawX;
    logic [Y_W-1:0]     w_rawY;
    logic [X_W-1:0]     w_capX;
    logic [Y_W-1:0]     w_capY;

    // Lowest still-enabled channel at or above the scan pointer; descending loop leaves the lowest hit.
    always_comb begin
        w_found   = 1'b0;
        w_scanIdx = '0;
        w_scanHot = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_mask[i] && (PTR_W'(i) >= r_ptr)) begin
                w_found      = 1'b1;
                w_scanIdx    = SEL_W'(i);
                w_scanHot    = '0;
                w_scanHot[i] = 1'b1;
            end
        end
    end

    assign w_maskRest  = r_mask & ~w_scanHot;
    assign w_transfer  = r_outValid && out_ready;
    assign w_free      = !r_outValid || out_ready;
    assign w_selValid  = ({1'b0, selector} < PTR_W'(NUM_CH));
    assign w_manualReq = (r_state == S_IDLE) && !mode && load && w_free;
    assign w_manualGo  = w_manualReq && w_selValid;
    assign w_manualErr = w_manualReq && !w_selValid;
    assign w_scanGo    = (r_state == S_SCAN) && w_free && w_found;
    assign w_capture   = w_manualGo || w_scanGo;
    assign w_capIdx    = (r_state == S_SCAN) ? w_scanIdx : selector;

    // Channel mux over the packed buses, driven by whichever source is capturing.
    always_comb begin
        w_rawX = '0;
        w_rawY = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (SEL_W'(i) == w_capIdx) begin
                w_rawX = x_bus[i*X_W +: X_W];
                w_rawY = y_bus[i*Y_W +: Y_W];
            end
        end
    end

    assign w_capX = (CLAMP_ON && (w_rawX > X_LIM)) ? X_LIM : w_rawX;
    assign w_capY = (CLAMP_ON && (w_rawY > Y_LIM)) ? Y_LIM : w_rawY;

    // Output slot, sequencing FSM and status pulses; the held beat only changes when the slot is free.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_mask     <= '0;
            r_ptr      <= '0;
            r_outX     <= '0;
            r_outY     <= '0;
            r_outCh    <= '0;
            r_outValid <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_selErr   <= 1'b0;
        end else begin
            r_done   <= 1'b0;
            r_selErr <= w_manualErr;

            if (w_capture) begin
                r_outX     <= w_capX;
                r_outY     <= w_capY;
                r_outCh    <= w_capIdx;
                r_outValid <= 1'b1;
            end else if (w_transfer) begin
                r_outValid <= 1'b0;
            end

            case (r_state)
                S_IDLE: begin
                    if (mode && start) begin
                        r_mask <= ch_en;
                        r_ptr  <= '0;
                        if (ch_en == '0) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= S_SCAN;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                S_SCAN: begin
                    if (w_scanGo) begin
                        r_mask <= w_maskRest;
                        r_ptr  <= {1'b0, w_scanIdx} + PTR_W'(1);
                        if (w_maskRest == '0) begin
                            r_state <= S_DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end else if (!w_found) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign out_x     = r_outX;
    assign out_y     = r_outY;
    assign out_ch    = r_outCh;
    assign out_valid = r_outValid;
    assign busy      = r_busy;
    assign done      = r_done;
    assign sel_err   = r_selErr;

endmodule
